// File: rtl/shader_sint_arb.sv
// Purpose : round-robin merge of the reflect and shadow ray streams into one registered queue feeding sint.
// Latency : one cycle from accept to shader_to_sint_valid when the queue was empty; 1 ray/cycle sustained.
// Backpressure: source stalls depend only on the registered occupancy, so shader_to_sint_stall never reaches a source combinationally.
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   reflect_valid/data/stall    reflect ray source (stall = offered but not taken)
//   shadow_valid/data/stall     shadow ray source
//   shader_to_sint_valid/data   queue head towards sint
//   shader_to_sint_stall        sint cannot take the head this cycle
//   reflect_issued/shadow_issued  wrapping per-class accept counters (debug)

package shader_sint_pkg;
  typedef struct packed {
    logic [7:0]   ray_id;
    logic [191:0] ray_vec;    // origin xyz + direction xyz, 32 bits each
    logic         is_shadow;
  } shader_to_sint_t;
endpackage

module shader_sint_arb
  import shader_sint_pkg::*;
#(
  parameter int DEPTH = 2,    // legal 2..8; 2 is the minimum for 1 ray/cycle
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reflect_valid,
  input  shader_to_sint_t reflect_data,
  output logic            reflect_stall,
  input  logic            shadow_valid,
  input  shader_to_sint_t shadow_data,
  output logic            shadow_stall,
  output logic            shader_to_sint_valid,
  output shader_to_sint_t shader_to_sint_data,
  input  logic            shader_to_sint_stall,
  output logic [CNTW-1:0] reflect_issued,
  output logic [CNTW-1:0] shadow_issued
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic { SRC_REFLECT = 1'b0, SRC_SHADOW = 1'b1 } src_e;

  shader_to_sint_t mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   count;
  src_e            last_grant;

  logic            space;
  logic            grant_refl;
  logic            grant_shad;
  logic            accept;
  logic            deq;
  shader_to_sint_t wr_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // Space comes only from the registered count: a same-cycle pop does not
    // free a slot, which keeps sint's stall off the source stall paths.
    space      = (count < CW'(DEPTH));
    grant_refl = reflect_valid && (!shadow_valid || (last_grant == SRC_SHADOW));
    grant_shad = shadow_valid  && (!reflect_valid || (last_grant == SRC_REFLECT));
    // Nothing is taken while reset is held, so both stalls show high then.
    accept     = (grant_refl || grant_shad) && space && rst;
    deq        = shader_to_sint_valid && !shader_to_sint_stall;

    // The port, not the incoming flag, decides the ray class.
    wr_data = grant_refl ? reflect_data : shadow_data;
    wr_data.is_shadow = grant_shad;

    reflect_stall = reflect_valid && !(accept && grant_refl);
    shadow_stall  = shadow_valid  && !(accept && grant_shad);
  end

  assign shader_to_sint_valid = (count != '0);
  assign shader_to_sint_data  = mem[head_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr       <= '0;
      tail_ptr       <= '0;
      count          <= '0;
      last_grant     <= SRC_SHADOW;
      reflect_issued <= '0;
      shadow_issued  <= '0;
    end else begin
      if (accept) begin
        tail_ptr <= ptr_inc(tail_ptr);
        if (grant_refl) begin
          last_grant     <= SRC_REFLECT;
          reflect_issued <= reflect_issued + 1'b1;
        end else begin
          last_grant    <= SRC_SHADOW;
          shadow_issued <= shadow_issued + 1'b1;
        end
      end
      if (deq) begin
        head_ptr <= ptr_inc(head_ptr);
      end
      case ({accept, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[tail_ptr] <= wr_data;
    end
  end

endmodule
